// File: rtl/decode_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_ctrl_if
//  Description : Fetch, issue and writeback signal bundle for the
//                decode/issue stage controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_issue_ctrl_if;
    // fetch side
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    // issue side
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic [2:0]  ex_fmt;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [31:0] ex_imm;
    logic        ex_illegal;
    // redirect and writeback
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;

    // Environment view: drives fetch, execute-ready, flush and writeback.
    modport master (
        output if_valid, if_instr, if_pc, ex_ready, flush, wb_valid, wb_rd,
        input  if_ready, ex_valid, ex_instr, ex_pc, ex_fmt, ex_rd, ex_rs1,
               ex_rs2, ex_imm, ex_illegal
    );

    // Decode/issue controller view.
    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready, flush, wb_valid, wb_rd,
        output if_ready, ex_valid, ex_instr, ex_pc, ex_fmt, ex_rd, ex_rs1,
               ex_rs2, ex_imm, ex_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_ctrl
//  Description : RV32I decode/issue controller. Classifies fetched
//                instructions, extracts register indices and immediates,
//                holds them in a one-entry issue register and blocks
//                acceptance on RAW/WAW hazards tracked by a busy scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_issue_ctrl (
    input wire logic           clk,
    input wire logic           reset,
    decode_issue_ctrl_if.slave bus
);

    localparam logic [6:0] c_OPC_LUI    = 7'h37;
    localparam logic [6:0] c_OPC_AUIPC  = 7'h17;
    localparam logic [6:0] c_OPC_OPIMM  = 7'h13;
    localparam logic [6:0] c_OPC_OP     = 7'h33;
    localparam logic [6:0] c_OPC_LOAD   = 7'h03;
    localparam logic [6:0] c_OPC_STORE  = 7'h23;
    localparam logic [6:0] c_OPC_BRANCH = 7'h63;
    localparam logic [6:0] c_OPC_JAL    = 7'h6F;
    localparam logic [6:0] c_OPC_JALR   = 7'h67;

    localparam logic [2:0] c_FMT_U      = 3'd0;
    localparam logic [2:0] c_FMT_I      = 3'd1;
    localparam logic [2:0] c_FMT_R      = 3'd2;
    localparam logic [2:0] c_FMT_LOAD   = 3'd3;
    localparam logic [2:0] c_FMT_STORE  = 3'd4;
    localparam logic [2:0] c_FMT_BRANCH = 3'd5;
    localparam logic [2:0] c_FMT_JAL    = 3'd6;
    localparam logic [2:0] c_FMT_JALR   = 3'd7;

    logic [31:0] w_instr;
    logic [2:0]  w_fmt;
    logic        w_illegal;
    logic        w_wr_rd;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic [31:0] w_imm;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_pend;
    logic        w_hazard;
    logic        w_if_ready;
    logic        w_accept;
    logic        w_issue;

    logic        r_ex_valid;
    logic [31:0] r_ex_instr;
    logic [31:0] r_ex_pc;
    logic [2:0]  r_ex_fmt;
    logic [4:0]  r_ex_rd;
    logic [4:0]  r_ex_rs1;
    logic [4:0]  r_ex_rs2;
    logic [31:0] r_ex_imm;
    logic        r_ex_illegal;
    logic [31:0] r_busy;

    assign w_instr = bus.if_instr;

    // Classify the incoming opcode and build its immediate.
    always_comb begin
        w_fmt     = c_FMT_U;
        w_illegal = 1'b0;
        w_wr_rd   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_imm     = '0;
        case (w_instr[6:0])
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_wr_rd = 1'b1;
                w_imm   = {w_instr[31:12], 12'b0};
            end
            c_OPC_OPIMM: begin
                w_fmt = c_FMT_I;  w_wr_rd = 1'b1; w_use_rs1 = 1'b1;
                w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            c_OPC_OP: begin
                w_fmt = c_FMT_R;  w_wr_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            c_OPC_LOAD: begin
                w_fmt = c_FMT_LOAD; w_wr_rd = 1'b1; w_use_rs1 = 1'b1;
                w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            c_OPC_STORE: begin
                w_fmt = c_FMT_STORE; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            c_OPC_BRANCH: begin
                w_fmt = c_FMT_BRANCH; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                         w_instr[30:25], w_instr[11:8], 1'b0};
            end
            c_OPC_JAL: begin
                w_fmt = c_FMT_JAL; w_wr_rd = 1'b1;
                w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                         w_instr[20], w_instr[30:21], 1'b0};
            end
            c_OPC_JALR: begin
                w_fmt = c_FMT_JALR; w_wr_rd = 1'b1; w_use_rs1 = 1'b1;
                w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Unused fields read as index 0, which is never pending.
    assign w_rd  = w_wr_rd   ? w_instr[11:7]  : 5'd0;
    assign w_rs1 = w_use_rs1 ? w_instr[19:15] : 5'd0;
    assign w_rs2 = w_use_rs2 ? w_instr[24:20] : 5'd0;

    // Pending registers: busy and not being written back this cycle, or
    // the destination of the instruction sitting in the issue register.
    // The held rd is zeroed for non-writing formats, so a nonzero match
    // already implies it writes rd.
    always_comb begin
        w_pend = '0;
        for (int i = 1; i < 32; i++) begin
            w_pend[i] = (r_busy[i] && !(bus.wb_valid && bus.wb_rd == 5'(i))) ||
                        (r_ex_valid && r_ex_rd == 5'(i));
        end
    end

    assign w_hazard   = !w_illegal && (w_pend[w_rs1] || w_pend[w_rs2] || w_pend[w_rd]);
    assign w_if_ready = !reset && !bus.flush && !w_hazard && (!r_ex_valid || bus.ex_ready);
    assign w_accept   = bus.if_valid && w_if_ready;
    assign w_issue    = r_ex_valid && bus.ex_ready;

    // Issue register: flush beats accept, accept beats drain-on-issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid   <= 1'b0;
            r_ex_instr   <= '0;
            r_ex_pc      <= '0;
            r_ex_fmt     <= '0;
            r_ex_rd      <= '0;
            r_ex_rs1     <= '0;
            r_ex_rs2     <= '0;
            r_ex_imm     <= '0;
            r_ex_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_ex_valid   <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid   <= 1'b1;
            r_ex_instr   <= w_instr;
            r_ex_pc      <= bus.if_pc;
            r_ex_fmt     <= w_fmt;
            r_ex_rd      <= w_rd;
            r_ex_rs1     <= w_rs1;
            r_ex_rs2     <= w_rs2;
            r_ex_imm     <= w_imm;
            r_ex_illegal <= w_illegal;
        end else if (w_issue) begin
            r_ex_valid   <= 1'b0;
        end
    end

    // Scoreboard: issue sets the destination, writeback clears; set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int i = 1; i < 32; i++) begin
                if (w_issue && r_ex_rd == 5'(i)) begin
                    r_busy[i] <= 1'b1;
                end else if (bus.wb_valid && bus.wb_rd == 5'(i)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.if_ready   = w_if_ready;
    assign bus.ex_valid   = r_ex_valid;
    assign bus.ex_instr   = r_ex_instr;
    assign bus.ex_pc      = r_ex_pc;
    assign bus.ex_fmt     = r_ex_fmt;
    assign bus.ex_rd      = r_ex_rd;
    assign bus.ex_rs1     = r_ex_rs1;
    assign bus.ex_rs2     = r_ex_rs2;
    assign bus.ex_imm     = r_ex_imm;
    assign bus.ex_illegal = r_ex_illegal;

endmodule
`default_nettype wire
